// File: rtl/alu54_sub_arb.sv
// Round-robin arbiter sharing one registered ALU54 subtractor among N requesters.
// Optional sticky grants via `define ALU54_SUB_ARB_LOCK_EN (adds req_lock input).
module alu54_sub_arb #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    req_valid,
`ifdef ALU54_SUB_ARB_LOCK_EN
  input  logic [N-1:0]    req_lock,
`endif
  output logic [N-1:0]    req_ready,
  input  logic [N*32-1:0] req_a,
  input  logic [N*32-1:0] req_b,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [IDW-1:0]  rsp_id,
  output logic [32:0]     rsp_data,
  output logic [31:0]     alu_a,
  output logic [31:0]     alu_b,
  output logic            alu_ce,
  input  logic [32:0]     alu_dout
);

  logic           stall;
  logic [IDW-1:0] ptr;
  logic           search_any;
  logic [IDW-1:0] search_idx;
  logic           grant_any;
  logic [IDW-1:0] grant_idx;
  logic           lock_hold;
  logic [IDW-1:0] next_ptr;
  logic [IDW-1:0] mux_sel;

  assign stall    = rsp_valid & ~rsp_ready;
  assign rsp_data = alu_dout;
  // Keep the ALU clocked in reset so its output register clears too.
  assign alu_ce   = reset | ~stall;

  always_comb begin
    logic [IDW-1:0] cand;
    search_any = 1'b0;
    search_idx = '0;
    cand       = '0;
    // Walk backwards so the candidate closest to ptr is the one that sticks.
    for (int k = N - 1; k >= 0; k--) begin
      cand = IDW'((int'(ptr) + k) % N);
      if (req_valid[cand]) begin
        search_any = 1'b1;
        search_idx = cand;
      end
    end
  end

`ifdef ALU54_SUB_ARB_LOCK_EN
  logic [IDW-1:0] last_g;
  logic           have_last;

  assign lock_hold = have_last & req_lock[last_g] & req_valid[last_g];

  always_ff @(posedge clk) begin
    if (reset) begin
      have_last <= 1'b0;
      last_g    <= '0;
    end else if (!stall) begin
      have_last <= grant_any;
      if (grant_any) last_g <= grant_idx;
    end
  end
`else
  assign lock_hold = 1'b0;
`endif

  always_comb begin
    grant_any = 1'b0;
    grant_idx = search_idx;
    if (!reset && !stall) begin
      if (lock_hold) begin
`ifdef ALU54_SUB_ARB_LOCK_EN
        grant_idx = last_g;
`endif
        grant_any = 1'b1;
      end else begin
        grant_any = search_any;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N; i++) begin
      req_ready[i] = grant_any && (grant_idx == IDW'(i));
    end
  end

  assign mux_sel = grant_any ? grant_idx : ptr;

  always_comb begin
    alu_a = req_a[31:0];
    alu_b = req_b[31:0];
    for (int i = 0; i < N; i++) begin
      if (mux_sel == IDW'(i)) begin
        alu_a = req_a[32*i +: 32];
        alu_b = req_b[32*i +: 32];
      end
    end
  end

  assign next_ptr = (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + 1'b1;

  // Response tracking mirrors the ALU register: both freeze together under stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      ptr       <= '0;
    end else if (!stall) begin
      rsp_valid <= grant_any;
      if (grant_any) begin
        rsp_id <= grant_idx;
        if (!lock_hold) ptr <= next_ptr;
      end
    end
  end

endmodule

// File: tb/tb_alu54_sub_arb.sv
// Scoreboard bench for alu54_sub_arb: a model predicts grants and results, a monitor checks responses.
module tb_alu54_sub_arb;
  localparam int N   = 4;
  localparam int IDW = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [32:0]    data;
  } rsp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_a;
  logic [N*32-1:0] req_b;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [IDW-1:0]  rsp_id;
  logic [32:0]     rsp_data;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;
  logic            alu_ce;
  logic [32:0]     alu_dout = '0;
`ifdef ALU54_SUB_ARB_LOCK_EN
  logic [N-1:0]    req_lock = '0;
`endif

  rsp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  alu54_sub_arb #(.N(N), .IDW(IDW)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
`ifdef ALU54_SUB_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ready(req_ready),
    .req_a(req_a),
    .req_b(req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_data(rsp_data),
    .alu_a(alu_a),
    .alu_b(alu_b),
    .alu_ce(alu_ce),
    .alu_dout(alu_dout)
  );

  // Stand-in for the registered ALU54 subtract wrapper.
  always @(posedge clk) begin
    if (alu_ce) alu_dout <= reset ? 33'd0 : ({alu_a[31], alu_a} - {alu_b[31], alu_b});
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic [N-1:0] v, input logic rr, input logic rst);
    req_valid = v;
    rsp_ready = rr;
    reset     = rst;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pickVal();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic randomOps();
    for (int i = 0; i < N; i++) begin
      req_a[32*i +: 32] = pickVal();
      req_b[32*i +: 32] = pickVal();
    end
  endtask

  task automatic setOps(input int idx, input logic [31:0] a, input logic [31:0] b);
    req_a[32*idx +: 32] = a;
    req_b[32*idx +: 32] = b;
  endtask

  // Monitor: every accepted response must match the oldest prediction.
  initial begin
    rsp_t item;
    forever begin
      @(negedge clk);
      if (!reset) begin
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(sb.size() != 0));
        if (rsp_valid && rsp_ready && sb.size() != 0) begin
          item = sb.pop_front();
          checkOutput("rsp_id", 64'(rsp_id), 64'(item.id));
          checkOutput("rsp_data", 64'(rsp_data), 64'(item.data));
        end
      end
    end
  end

  // Reference model: round-robin by search from a pointer, results by plain signed subtraction.
  initial begin
    int          mptr;
    int          g;
    int          idx;
    bit          stall;
    logic [N-1:0] exp_ready;
    logic signed [32:0] sa;
    logic signed [32:0] sbv;
    rsp_t        item;
    mptr = 0;
    forever begin
      @(negedge clk);
      #1;
      if (reset) begin
        sb.delete();
        mptr = 0;
        checkOutput("req_ready_in_reset", 64'(req_ready), 64'd0);
        checkOutput("alu_ce_in_reset", 64'(alu_ce), 64'd1);
      end else begin
        stall = (sb.size() != 0) && !rsp_ready;
        g = -1;
        if (!stall) begin
          for (int k = 0; k < N; k++) begin
            idx = (mptr + k) % N;
            if (g < 0 && req_valid[idx]) g = idx;
          end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
        checkOutput("alu_ce", 64'(alu_ce), 64'(!stall));
        if (g >= 0) begin
          sa        = signed'({req_a[32*g+31], req_a[32*g +: 32]});
          sbv       = signed'({req_b[32*g+31], req_b[32*g +: 32]});
          item.id   = IDW'(g);
          item.data = 33'(sa - sbv);
          sb.push_back(item);
          mptr = (g + 1) % N;
        end
      end
    end
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    req_a     = '0;
    req_b     = '0;
    repeat (3) applyStimulus('0, 1'b1, 1'b1);

    // Basic issue, then negative and no-wrap results.
    setOps(0, 32'd10, 32'd3);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);
    setOps(0, 32'd0, 32'd1);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    setOps(0, 32'h8000_0000, 32'd1);
    applyStimulus(4'b0001, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);

    // All requesters busy: rotating grants, one result per cycle.
    repeat (8) begin
      randomOps();
      applyStimulus(4'b1111, 1'b1, 1'b0);
    end

    // Backpressure with pending requests, then release.
    repeat (4) applyStimulus(4'b1111, 1'b0, 1'b0);
    randomOps();
    applyStimulus(4'b1111, 1'b1, 1'b0);
    applyStimulus(4'b0000, 1'b1, 1'b0);

    // Reset right after an issue.
    applyStimulus(4'b1111, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b1);
    applyStimulus(4'b1111, 1'b1, 1'b0);
    applyStimulus(4'b1111, 1'b1, 1'b0);

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      randomOps();
      applyStimulus(N'($urandom), ($urandom_range(0, 9) < 7), ($urandom_range(0, 199) == 0));
    end

    repeat (4) applyStimulus('0, 1'b1, 1'b0);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
